apu_frame_sequencer: RTL and testbench
======================================

Name: apu_frame_sequencer

Overview:
- Frame counter / scheduler for the APU channel datapath.
- Divides the APU tick enable into quarter-frame and half-frame event pulses. These pulses clock the envelope, sweep and length units.
- Supports NES 4-step and 5-step modes, selected by a config byte written from the serial register file.
- Raises a frame IRQ flag in 4-step mode unless inhibited.

Parameters:
- CNT_W, 16: width of the tick counter; must hold Q5.
- Q1, 7457: tick count of step 1 event.
- Q2, 14913: tick count of step 2 event.
- Q3, 22371: tick count of step 3 event.
- Q4, 29829: tick count of step 4 event; last count in 4-step mode.
- Q5, 37281: tick count of step 5 event; last count in 5-step mode.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  APU cycle enable, one clk wide; counter advances only when high.
- cfg_wr  in  1  one-cycle strobe; cfg_data is valid in that cycle, already in the clk domain.
- cfg_data  in  8  bit7 = mode (0 = 4-step, 1 = 5-step); bit6 = irq_inhibit; other bits ignored.
- irq_clr  in  1  one-cycle strobe; clears the IRQ flag (status read).
- qtr_pulse  out  1  quarter-frame event, one clk wide.
- half_pulse  out  1  half-frame event, one clk wide.
- irq  out  1  frame IRQ flag, level.
- mode  out  1  currently latched mode bit.
- step  out  3  index of the last step fired: 0 = none since restart, 1..5.

Behaviour:
- Reset (asynchronous, rst_n low):
  - cnt = 0, mode = 0, irq_inhibit = 0.
  - irq = 0, qtr_pulse = 0, half_pulse = 0, step = 0.
  - Reset asserted mid-frame discards all progress; no pulse is emitted on release.
- Counter:
  - On tick, decode cnt before increment.
  - LAST = Q4 in 4-step mode, Q5 in 5-step mode.
  - cnt == LAST: cnt <= 0. Otherwise: cnt <= cnt + 1 (CNT_W-bit, never overflows).
  - Frame period is LAST+1 ticks: 29830 (4-step), 37282 (5-step).
- Events, decoded on a tick at cnt == Qn and registered, so pulses appear the clk cycle after that tick:
  - Q1: qtr; step = 1.
  - Q2: qtr + half; step = 2.
  - Q3: qtr; step = 3.
  - Q4, 4-step mode: qtr + half; irq set if !irq_inhibit; step = 4.
  - Q4, 5-step mode: no pulse; step = 4.
  - Q5, 5-step mode only: qtr + half; step = 5.
  - No tick means no event, regardless of cnt.
- cfg_wr:
  - Latch mode and irq_inhibit; cnt <= 0; step <= 0.
  - New irq_inhibit = 1: irq <= 0 in the same cycle.
  - New mode = 5-step: qtr_pulse and half_pulse are both asserted in the next cycle (immediate clock).
  - New mode = 4-step: no pulse.
  - A tick in the same cycle as cfg_wr is ignored (cfg_wr has priority).
- IRQ flag:
  - Priority: set > irq_clr > hold.
  - irq_clr coincident with a Q4 set leaves irq = 1.
  - irq_clr while irq = 0 has no effect.
  - The flag never sets in 5-step mode.
- Pulses are never stretched. Back-to-back ticks give at most one pulse per qualifying tick.
- The Q parameters must be strictly increasing. The bench checks this; the RTL does not.

Decomposition:
- Shared package apu_pkg holds:
  - default Q1..Q5 localparams;
  - cfg bit positions CFG_MODE_BIT = 7 and CFG_INHIBIT_BIT = 6;
  - a step index enum.
- Single module; no sub-module required.
- The equality decode against Q1..Q5 stays as one combinational block feeding the pulse registers.

Test Plan:
- Reset, then tick every cycle in 4-step mode, irq_inhibit = 0:
  - qtr_pulse after ticks 7458, 14914, 22372 and 29830;
  - half_pulse after ticks 14914 and 29830;
  - irq rises after tick 29830;
  - the next qtr_pulse comes after tick 37288 (period 29830).
- cfg_wr with cfg_data = 0x80 mid-frame:
  - qtr_pulse = half_pulse = 1 on the next cycle;
  - no pulse at the step-4 point;
  - qtr + half after 37282 ticks;
  - irq stays 0 throughout.
- 4-step mode, irq = 1, then cfg_wr with cfg_data = 0x40: irq = 0 next cycle and never sets at subsequent Q4 points.
- irq_clr asserted in the same cycle as the Q4 set: irq = 1. A lone irq_clr one cycle later: irq = 0.
- cfg_wr and tick in the same cycle at cnt = 100: cnt = 0 afterwards, not 1; the next qtr_pulse comes Q1+1 ticks later.
- rst_n low for one cycle at cnt = Q2−1:
  - all outputs 0 immediately (asynchronous);
  - no half_pulse at the original Q2 point;
  - mode returns to 4-step.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame sequencer: default step tick
// counts, config byte bit positions and the step index encoding.
package apu_pkg;

  localparam int unsigned Q1_DEF = 7457;
  localparam int unsigned Q2_DEF = 14913;
  localparam int unsigned Q3_DEF = 22371;
  localparam int unsigned Q4_DEF = 29829;
  localparam int unsigned Q5_DEF = 37281;

  localparam int unsigned CFG_MODE_BIT    = 7;
  localparam int unsigned CFG_INHIBIT_BIT = 6;

  typedef enum logic [2:0] {
    StepNone = 3'd0,
    Step1    = 3'd1,
    Step2    = 3'd2,
    Step3    = 3'd3,
    Step4    = 3'd4,
    Step5    = 3'd5
  } step_e;

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: divides the tick enable into quarter/half-frame pulses
// for 4-step and 5-step modes and raises the frame IRQ in 4-step mode.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned Q1    = Q1_DEF,
  parameter int unsigned Q2    = Q2_DEF,
  parameter int unsigned Q3    = Q3_DEF,
  parameter int unsigned Q4    = Q4_DEF,
  parameter int unsigned Q5    = Q5_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_data,
  input  logic       irq_clr,
  output logic       qtr_pulse,
  output logic       half_pulse,
  output logic       irq,
  output logic       mode,
  output logic [2:0] step
);

  localparam logic [CNT_W-1:0] Q1C = CNT_W'(Q1);
  localparam logic [CNT_W-1:0] Q2C = CNT_W'(Q2);
  localparam logic [CNT_W-1:0] Q3C = CNT_W'(Q3);
  localparam logic [CNT_W-1:0] Q4C = CNT_W'(Q4);
  localparam logic [CNT_W-1:0] Q5C = CNT_W'(Q5);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             inh_q, inh_d;
  logic             irq_q, irq_d;
  logic             qtr_q, qtr_d;
  logic             half_q, half_d;
  step_e            step_q, step_d;

  logic [CNT_W-1:0] last;
  logic             irq_set;
  logic             cfg_mode, cfg_inh;

  // Only the mode and inhibit bits of the config byte carry meaning.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_data[5:0];

  assign cfg_mode = cfg_data[CFG_MODE_BIT];
  assign cfg_inh  = cfg_data[CFG_INHIBIT_BIT];
  assign last     = mode_q ? Q5C : Q4C;

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    inh_d   = inh_q;
    step_d  = step_q;
    qtr_d   = 1'b0;
    half_d  = 1'b0;
    irq_set = 1'b0;

    if (cfg_wr) begin
      // A config write restarts the frame; 5-step mode clocks the units at once.
      mode_d = cfg_mode;
      inh_d  = cfg_inh;
      cnt_d  = '0;
      step_d = StepNone;
      qtr_d  = cfg_mode;
      half_d = cfg_mode;
    end else if (tick) begin
      cnt_d = (cnt_q == last) ? '0 : cnt_q + 1'b1;
      if (cnt_q == Q1C) begin
        qtr_d  = 1'b1;
        step_d = Step1;
      end
      if (cnt_q == Q2C) begin
        qtr_d  = 1'b1;
        half_d = 1'b1;
        step_d = Step2;
      end
      if (cnt_q == Q3C) begin
        qtr_d  = 1'b1;
        step_d = Step3;
      end
      if (cnt_q == Q4C) begin
        step_d = Step4;
        if (!mode_q) begin
          qtr_d   = 1'b1;
          half_d  = 1'b1;
          irq_set = !inh_q;
        end
      end
      if (cnt_q == Q5C && mode_q) begin
        qtr_d  = 1'b1;
        half_d = 1'b1;
        step_d = Step5;
      end
    end

    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clr || (cfg_wr && cfg_inh)) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      irq_q  <= 1'b0;
      qtr_q  <= 1'b0;
      half_q <= 1'b0;
      step_q <= StepNone;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      irq_q  <= irq_d;
      qtr_q  <= qtr_d;
      half_q <= half_d;
      step_q <= step_d;
    end
  end

  assign qtr_pulse  = qtr_q;
  assign half_pulse = half_q;
  assign irq        = irq_q;
  assign mode       = mode_q;
  assign step       = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with scaled-down step counts so whole
// frames in both modes fit in a short run.
module tb_apu_frame_sequencer;

  localparam int unsigned TQ1 = 149;
  localparam int unsigned TQ2 = 298;
  localparam int unsigned TQ3 = 447;
  localparam int unsigned TQ4 = 596;
  localparam int unsigned TQ5 = 745;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       irq_clr = 1'b0;
  logic       qtr_pulse, half_pulse, irq, mode;
  logic [2:0] step;

  int n_checks = 0;
  int n_fail = 0;

  apu_frame_sequencer #(
    .CNT_W(16), .Q1(TQ1), .Q2(TQ2), .Q3(TQ3), .Q4(TQ4), .Q5(TQ5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .cfg_wr    (cfg_wr),
    .cfg_data  (cfg_data),
    .irq_clr   (irq_clr),
    .qtr_pulse (qtr_pulse),
    .half_pulse(half_pulse),
    .irq       (irq),
    .mode      (mode),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] d);
    cfg_wr   = 1'b1;
    cfg_data = d;
    cyc();
    cfg_wr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({qtr_pulse, half_pulse, irq, mode, step} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000", {qtr_pulse, half_pulse, irq, mode, step});
    end
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({qtr_pulse, half_pulse, irq, mode, step} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000000", {qtr_pulse, half_pulse, irq, mode, step});
    end
  endtask

  task automatic test_4step();
    int total = TQ4 + 1 + TQ1 + 1;
    for (int k = 1; k <= total; k++) begin
      logic eq, eh, ei;
      tick = 1'b1;
      cyc();
      eq = (k == TQ1 + 1) || (k == TQ2 + 1) || (k == TQ3 + 1) || (k == TQ4 + 1) || (k == total);
      eh = (k == TQ2 + 1) || (k == TQ4 + 1);
      ei = (k >= TQ4 + 1);
      n_checks++;
      if ({qtr_pulse, half_pulse, irq} !== {eq, eh, ei}) begin
        n_fail++;
        $display("FAIL 4step_pulses k=%0d: got qhi=%b%b%b want %b%b%b",
                 k, qtr_pulse, half_pulse, irq, eq, eh, ei);
      end
      if (k == TQ4 + 1 || k == total) begin
        n_checks++;
        if (step !== ((k == total) ? 3'd1 : 3'd4)) begin
          n_fail++;
          $display("FAIL 4step_step k=%0d: got %0d want %0d", k, step, (k == total) ? 1 : 4);
        end
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_inhibit();
    write_cfg(8'h40);
    n_checks++;
    if ({irq, qtr_pulse, half_pulse, mode, step} !== 7'b0) begin
      n_fail++;
      $display("FAIL inhibit_cfg: got %b want 0000000", {irq, qtr_pulse, half_pulse, mode, step});
    end
    for (int k = 1; k <= TQ4 + 1; k++) begin
      tick = 1'b1;
      cyc();
      n_checks++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL inhibit_irq k=%0d: got %b want 0", k, irq);
      end
      if (k == TQ4 + 1) begin
        n_checks++;
        if ({qtr_pulse, half_pulse} !== 2'b11) begin
          n_fail++;
          $display("FAIL inhibit_q4_pulse: got %b%b want 11", qtr_pulse, half_pulse);
        end
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_irq_clr();
    write_cfg(8'h00);
    tick = 1'b1;
    repeat (TQ4) cyc();
    irq_clr = 1'b1;
    cyc();
    tick = 1'b0;
    n_checks++;
    if ({irq, half_pulse, step} !== {1'b1, 1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL irq_clr_vs_set: got irq=%b half=%b step=%0d want 1 1 4", irq, half_pulse, step);
    end
    cyc();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clr_lone: got %b want 0", irq);
    end
    cyc();
    irq_clr = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clr_idle: got %b want 0", irq);
    end
  endtask

  task automatic test_5step();
    tick = 1'b1;
    repeat (50) cyc();
    tick = 1'b0;
    write_cfg(8'h80);
    n_checks++;
    if ({qtr_pulse, half_pulse, mode, step} !== {3'b111, 3'd0}) begin
      n_fail++;
      $display("FAIL 5step_immediate: got %b want 111000", {qtr_pulse, half_pulse, mode, step});
    end
    cyc();
    n_checks++;
    if ({qtr_pulse, half_pulse} !== 2'b00) begin
      n_fail++;
      $display("FAIL 5step_no_stretch: got %b%b want 00", qtr_pulse, half_pulse);
    end
    for (int k = 1; k <= TQ5 + 1; k++) begin
      logic eq, eh;
      tick = 1'b1;
      cyc();
      eq = (k == TQ1 + 1) || (k == TQ2 + 1) || (k == TQ3 + 1) || (k == TQ5 + 1);
      eh = (k == TQ2 + 1) || (k == TQ5 + 1);
      n_checks++;
      if ({qtr_pulse, half_pulse, irq} !== {eq, eh, 1'b0}) begin
        n_fail++;
        $display("FAIL 5step_pulses k=%0d: got qhi=%b%b%b want %b%b0",
                 k, qtr_pulse, half_pulse, irq, eq, eh);
      end
      if (k == TQ4 + 1 || k == TQ5 + 1) begin
        n_checks++;
        if (step !== ((k == TQ5 + 1) ? 3'd5 : 3'd4)) begin
          n_fail++;
          $display("FAIL 5step_step k=%0d: got %0d want %0d", k, step, (k == TQ5 + 1) ? 5 : 4);
        end
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_cfg_tick();
    write_cfg(8'h00);
    tick = 1'b1;
    repeat (100) cyc();
    cfg_wr   = 1'b1;
    cfg_data = 8'h00;
    cyc();
    cfg_wr = 1'b0;
    n_checks++;
    if ({qtr_pulse, half_pulse, step} !== 5'b0) begin
      n_fail++;
      $display("FAIL cfg_tick_restart: got %b want 00000", {qtr_pulse, half_pulse, step});
    end
    for (int k = 1; k <= TQ1 + 1; k++) begin
      cyc();
      n_checks++;
      if (qtr_pulse !== (k == TQ1 + 1)) begin
        n_fail++;
        $display("FAIL cfg_tick_q1 k=%0d: got %b want %b", k, qtr_pulse, (k == TQ1 + 1));
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset_mid();
    write_cfg(8'h80);
    tick = 1'b1;
    repeat (TQ2 - 1) cyc();
    tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({qtr_pulse, half_pulse, irq, mode, step} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0000000", {qtr_pulse, half_pulse, irq, mode, step});
    end
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= TQ1 + 1; k++) begin
      tick = 1'b1;
      cyc();
      n_checks++;
      if ({qtr_pulse, half_pulse, mode} !== {(k == TQ1 + 1), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_restart k=%0d: got qhm=%b%b%b want %b00",
                 k, qtr_pulse, half_pulse, mode, (k == TQ1 + 1));
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    if (!(TQ1 < TQ2 && TQ2 < TQ3 && TQ3 < TQ4 && TQ4 < TQ5)) begin
      $display("FAIL q_order: step counts not strictly increasing");
      $fatal(1);
    end
    test_reset();
    test_4step();
    test_inhibit();
    test_irq_clr();
    test_5step();
    test_cfg_tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
